// File: rtl/fproc_pkg.sv
// Shared types for the fproc dq forward-pass unit.
// Holds link sizing, FSM states and the pair tag.
package fproc_pkg;

  localparam int LINK_W    = 3;
  localparam int NUM_LINKS = 7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic              valid;
    logic [LINK_W-1:0] link;
    logic [LINK_W-1:0] jidx;
  } pair_tag_t;

endpackage

// File: rtl/dqfp_tag_pipe.sv
// Two-stage {valid, link, jidx} tracker for stages 2 and 3.
// Also answers "is this pair in flight" for the hazard check.
module dqfp_tag_pipe
  import fproc_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  pair_tag_t         s1_tag_in,
  input  logic [LINK_W-1:0] q_link_in,
  input  logic [LINK_W-1:0] q_jidx_in,
  output pair_tag_t         s2_tag_out,
  output pair_tag_t         s3_tag_out,
  output logic              hit_out
);

  pair_tag_t s2_q, s2_d;
  pair_tag_t s3_q, s3_d;

  // shift the tags one stage per cycle
  always_comb begin
    s2_d = s1_tag_in;
    s3_d = s2_q;
  end

  // tag registers, cleared on reset
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  // hazard compare against both in-flight stages
  always_comb begin
    hit_out = 1'b0;
    if (s2_q.valid && s2_q.link == q_link_in
        && s2_q.jidx == q_jidx_in)
      hit_out = 1'b1;
    if (s3_q.valid && s3_q.link == q_link_in
        && s3_q.jidx == q_jidx_in)
      hit_out = 1'b1;
  end

  assign s2_tag_out = s2_q;
  assign s3_tag_out = s3_q;

endmodule

// File: rtl/dqfp_sched.sv
// Issue scheduler for the folded dq forward pass.
// DQFP_SCHED_STATS_EN adds issue/bubble counters.
module dqfp_sched
  import fproc_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start_in,
  input  logic [LINK_W-1:0] nlinks_in,
  input  logic              ready_in,
  output logic              s1_bool_out,
  output logic              s2_bool_out,
  output logic              s3_bool_out,
  output logic [LINK_W-1:0] link_out,
  output logic [LINK_W-1:0] jidx_out,
  output logic              mcross_out,
  output logic              wr_en_out,
  output logic [LINK_W-1:0] link_s3_out,
  output logic [LINK_W-1:0] jidx_s3_out,
  output logic              busy_out,
`ifdef DQFP_SCHED_STATS_EN
  output logic [15:0]       issue_cnt_out,
  output logic [15:0]       bubble_cnt_out,
`endif
  output logic              done_out
);

  localparam logic [LINK_W-1:0] NL_MAX = LINK_W'(NUM_LINKS);
  localparam logic [LINK_W-1:0] ONE    = LINK_W'(1);

  state_e            state_q, state_d;
  logic [LINK_W-1:0] i_q, i_d;
  logic [LINK_W-1:0] j_q, j_d;
  logic [LINK_W-1:0] nl_q, nl_d;
  logic [LINK_W-1:0] nl_clamp;
  logic              issue, bubble, hazard, hit;
  logic              accept;
  pair_tag_t         s1_tag, s2_tag, s3_tag;

  assign nl_clamp = (nlinks_in > NL_MAX) ? NL_MAX : nlinks_in;

  dqfp_tag_pipe u_pipe (
    .clk        (clk),
    .reset      (reset),
    .s1_tag_in  (s1_tag),
    .q_link_in  (i_q - ONE),
    .q_jidx_in  (j_q),
    .s2_tag_out (s2_tag),
    .s3_tag_out (s3_tag),
    .hit_out    (hit)
  );

  // next state, pair advance and stage-1 outputs
  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    j_d         = j_q;
    nl_d        = nl_q;
    issue       = 1'b0;
    bubble      = 1'b0;
    accept      = 1'b0;
    hazard      = (j_q < i_q) && hit;
    s1_tag      = '0;
    link_out    = '0;
    jidx_out    = '0;
    mcross_out  = 1'b0;
    busy_out    = 1'b0;
    done_out    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_in) begin
          accept  = 1'b1;
          nl_d    = nl_clamp;
          i_d     = ONE;
          j_d     = ONE;
          state_d = (nl_clamp == '0) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        busy_out = 1'b1;
        link_out = i_q;
        jidx_out = j_q;
        if (ready_in && !hazard) begin
          issue      = 1'b1;
          mcross_out = (j_q == i_q);
          if (j_q < i_q) begin
            j_d = j_q + ONE;
          end else begin
            i_d = i_q + ONE;
            j_d = ONE;
          end
          if (i_q == nl_q && j_q == i_q)
            state_d = ST_DRAIN;
        end else begin
          bubble = 1'b1;
        end
      end
      ST_DRAIN: begin
        busy_out = 1'b1;
        if (!s2_tag.valid)
          state_d = ST_DONE;
      end
      ST_DONE: begin
        done_out = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    s1_tag.valid = issue;
    s1_tag.link  = issue ? i_q : '0;
    s1_tag.jidx  = issue ? j_q : '0;
  end

  assign s1_bool_out = issue;
  assign s2_bool_out = s2_tag.valid;
  assign s3_bool_out = s3_tag.valid;
  assign wr_en_out   = s3_tag.valid;
  assign link_s3_out = s3_tag.link;
  assign jidx_s3_out = s3_tag.jidx;

  // FSM and pair counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      nl_q    <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      nl_q    <= nl_d;
    end
  end

`ifdef DQFP_SCHED_STATS_EN
  logic [15:0] issue_cnt_q, issue_cnt_d;
  logic [15:0] bubble_cnt_q, bubble_cnt_d;

  // saturating counters, cleared by each accepted start
  always_comb begin
    issue_cnt_d  = issue_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (accept) begin
      issue_cnt_d  = '0;
      bubble_cnt_d = '0;
    end else begin
      if (issue && issue_cnt_q != '1)
        issue_cnt_d = issue_cnt_q + 16'd1;
      if (bubble && bubble_cnt_q != '1)
        bubble_cnt_d = bubble_cnt_q + 16'd1;
    end
  end

  // counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      issue_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      issue_cnt_q  <= issue_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign issue_cnt_out  = issue_cnt_q;
  assign bubble_cnt_out = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_dqfp_sched.sv
// Directed bench for dqfp_sched.
// Cycle tables plus hand-written corner sequences.
module tb_dqfp_sched;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_in;
  logic [2:0] nlinks_in;
  logic       ready_in;
  logic       s1, s2, s3, mc, wr, busy, done;
  logic [2:0] link, jidx, l3, j3;
`ifdef DQFP_SCHED_STATS_EN
  logic [15:0] icnt, bcnt;
`endif

  int nchk = 0;
  int nerr = 0;

  int r_s1[64], r_s2[64], r_s3[64], r_mc[64];
  int r_wr[64], r_busy[64], r_done[64];
  int r_link[64], r_jidx[64], r_l3[64], r_j3[64];
  int r_icnt[64], r_bcnt[64];

  typedef struct {
    int cyc;
    int s1, link, jidx, mc;
    int wr, l3, j3, busy, done;
  } vec_t;

  vec_t tab[$];

  always #5 clk = ~clk;

  dqfp_sched dut (
    .clk         (clk),
    .reset       (reset),
    .start_in    (start_in),
    .nlinks_in   (nlinks_in),
    .ready_in    (ready_in),
    .s1_bool_out (s1),
    .s2_bool_out (s2),
    .s3_bool_out (s3),
    .link_out    (link),
    .jidx_out    (jidx),
    .mcross_out  (mc),
    .wr_en_out   (wr),
    .link_s3_out (l3),
    .jidx_s3_out (j3),
    .busy_out    (busy),
`ifdef DQFP_SCHED_STATS_EN
    .issue_cnt_out  (icnt),
    .bubble_cnt_out (bcnt),
`endif
    .done_out    (done)
  );

  task automatic chk(input string nm, input int act,
                     input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  // one run from start acceptance; records cycles 0..ncyc-1
  task automatic run(input int nl, input int rlo_s,
                     input int rlo_e, input int sp,
                     input int snl, input int rc,
                     input int maxc, output int ncyc);
    bit fin;
    fin = 0;
    ncyc = 0;
    nlinks_in = 3'(nl);
    start_in = 1'b1;
    ready_in = 1'b1;
    @(posedge clk); #1;
    start_in = 1'b0;
    for (int c = 0; c < maxc; c++) begin
      ready_in = !(c >= rlo_s && c <= rlo_e);
      start_in = (c == sp);
      if (c == sp) nlinks_in = 3'(snl);
      reset = (c == rc);
      #1;
      r_s1[c] = s1;   r_s2[c] = s2;   r_s3[c] = s3;
      r_mc[c] = mc;   r_wr[c] = wr;   r_busy[c] = busy;
      r_done[c] = done;
      r_link[c] = link; r_jidx[c] = jidx;
      r_l3[c] = l3;   r_j3[c] = j3;
`ifdef DQFP_SCHED_STATS_EN
      r_icnt[c] = icnt; r_bcnt[c] = bcnt;
`else
      r_icnt[c] = 0;  r_bcnt[c] = 0;
`endif
      ncyc = c + 1;
      if (done || (rc >= 0 && c == rc + 1)) fin = 1;
      @(posedge clk); #1;
      if (fin) break;
    end
    start_in = 1'b0;
    reset = 1'b0;
    ready_in = 1'b1;
    if (!fin) chk("run_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  function automatic int find_issue(int n, int li, int ji);
    for (int c = 0; c < n; c++)
      if (r_s1[c] == 1 && r_link[c] == li && r_jidx[c] == ji)
        return c;
    return -1;
  endfunction

  initial begin
    int n, k, mi, mj, cnt, last, bub;
    reset = 1'b1;
    start_in = 1'b0;
    ready_in = 1'b1;
    nlinks_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s1", s1, 0);
    chk("rst_s3", s3, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_link", link, 0);
    chk("rst_wr", wr, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // full nlinks=7 schedule
    tab.push_back('{0, 1,1,1,1, 0,0,0,1,0});
    tab.push_back('{1, 0,2,1,0, 0,0,0,1,0});
    tab.push_back('{2, 0,2,1,0, 1,1,1,1,0});
    tab.push_back('{3, 1,2,1,0, 0,0,0,1,0});
    tab.push_back('{4, 1,2,2,1, 0,0,0,1,0});
    tab.push_back('{5, 0,3,1,0, 1,2,1,1,0});
    tab.push_back('{6, 1,3,1,0, 1,2,2,1,0});
    tab.push_back('{7, 1,3,2,0, 0,0,0,1,0});
    tab.push_back('{8, 1,3,3,1, 1,3,1,1,0});
    tab.push_back('{9, 1,4,1,0, 1,3,2,1,0});
    tab.push_back('{10, 1,4,2,0, 1,3,3,1,0});
    tab.push_back('{30, 1,7,7,1, 1,7,5,1,0});
    tab.push_back('{31, 0,0,0,0, 1,7,6,1,0});
    tab.push_back('{32, 0,0,0,0, 1,7,7,1,0});
    tab.push_back('{33, 0,0,0,0, 0,0,0,0,1});

    run(7, 100, 100, -1, 0, -1, 60, n);
    chk("n7_len", n, 34);
    foreach (tab[t]) begin
      automatic vec_t v = tab[t];
      automatic int c = v.cyc;
      chk($sformatf("n7_s1_c%0d", c), r_s1[c], v.s1);
      chk($sformatf("n7_link_c%0d", c), r_link[c], v.link);
      chk($sformatf("n7_jidx_c%0d", c), r_jidx[c], v.jidx);
      chk($sformatf("n7_mc_c%0d", c), r_mc[c], v.mc);
      chk($sformatf("n7_wr_c%0d", c), r_wr[c], v.wr);
      chk($sformatf("n7_l3_c%0d", c), r_l3[c], v.l3);
      chk($sformatf("n7_j3_c%0d", c), r_j3[c], v.j3);
      chk($sformatf("n7_busy_c%0d", c), r_busy[c], v.busy);
      chk($sformatf("n7_done_c%0d", c), r_done[c], v.done);
    end
`ifdef DQFP_SCHED_STATS_EN
    chk("n7_issue_cnt", r_icnt[33], 28);
    chk("n7_bubble_cnt", r_bcnt[33], 3);
`endif
    // issue order, write tags and mcross follow (1,1),(2,1),(2,2)...
    mi = 1; mj = 1; cnt = 0;
    for (int c = 0; c < n; c++) begin
      if (r_wr[c] == 1) begin
        chk($sformatf("n7_wtag_l_%0d", cnt), r_l3[c], mi);
        chk($sformatf("n7_wtag_j_%0d", cnt), r_j3[c], mj);
        cnt++;
        if (mj < mi) mj++;
        else begin mi++; mj = 1; end
      end
    end
    chk("n7_wr_count", cnt, 28);
    mi = 1; mj = 1; k = 0;
    for (int c = 0; c < n; c++) begin
      if (r_s1[c] == 1) begin
        chk($sformatf("n7_iss_%0d", k),
            r_link[c] * 8 + r_jidx[c], mi * 8 + mj);
        chk($sformatf("n7_mc_%0d", k), r_mc[c],
            (mi == mj) ? 1 : 0);
        k++;
        if (mj < mi) mj++;
        else begin mi++; mj = 1; end
      end else begin
        chk($sformatf("n7_mc_idle_c%0d", c), r_mc[c], 0);
      end
    end
    chk("n7_issue_count", k, 28);

    // nlinks=1
    run(1, 100, 100, -1, 0, -1, 20, n);
    chk("n1_s1_c0", r_s1[0], 1);
    chk("n1_mc_c0", r_mc[0], 1);
    chk("n1_wr_c2", r_wr[2], 1);
    chk("n1_tag_c2", r_l3[2] * 8 + r_j3[2], 9);
    chk("n1_s1_c1", r_s1[1], 0);
    chk("n1_done_c3", r_done[3], 1);
    chk("n1_len", n, 4);

    // ready low on c3..c5
    run(7, 3, 5, -1, 0, -1, 60, n);
    chk("rl_21_at", find_issue(n, 2, 1), 6);
    chk("rl_31_at", find_issue(n, 3, 1), 9);
    last = find_issue(n, 7, 7);
    chk("rl_77_at", last, 33);
    bub = 0;
    for (int c = 0; c <= last && c < n; c++)
      if (r_s1[c] == 0) bub++;
    chk("rl_bubbles", bub, 6);
    chk("rl_done", n - 1, 36);
    chk("rl_done_v", r_done[n - 1], 1);
`ifdef DQFP_SCHED_STATS_EN
    chk("rl_bubble_cnt", r_bcnt[n - 1], 6);
`endif

    // nlinks=0
    run(0, 100, 100, -1, 0, -1, 10, n);
    chk("n0_done_c0", r_done[0], 1);
    chk("n0_len", n, 1);
    chk("n0_strobes", r_s1[0] + r_s2[0] + r_s3[0], 0);
    chk("n0_busy", r_busy[0], 0);

    // ignored start at c10, reset at c12
    run(7, 100, 100, 10, 1, 12, 30, n);
    chk("sr_len", n, 14);
    chk("sr_c10", r_link[10] * 8 + r_jidx[10], 34);
    chk("sr_c11", r_link[11] * 8 + r_jidx[11], 35);
    chk("sr_c12", r_link[12] * 8 + r_jidx[12], 36);
    chk("sr_s1_c12", r_s1[12], 1);
    chk("sr_mc_c12", r_mc[12], 1);
    chk("sr_wr_c12", r_wr[12], 1);
    chk("sr_c13_bits",
        r_s1[13] + r_s2[13] + r_s3[13] + r_mc[13]
        + r_wr[13] + r_busy[13] + r_done[13], 0);
    chk("sr_c13_tags",
        r_link[13] + r_jidx[13] + r_l3[13] + r_j3[13], 0);
    run(2, 100, 100, -1, 0, -1, 30, n);
    chk("rs_c0", r_link[0] * 8 + r_jidx[0], 9);
    chk("rs_s1_c0", r_s1[0], 1);
    chk("rs_21_at", find_issue(n, 2, 1), 3);
    chk("rs_done", n - 1, 7);

    $display("Simulation finished: %0d checks, %0d errors",
             nchk, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
